// File: rtl/store_pkg.sv
// Shared types and helpers for the store unit: funct3 codes, FIFO entry layout,
// FSM states and the byte-lane formatter used to build memory write beats.
package store_pkg;

    localparam logic [2:0] F3_SB = 3'b000;
    localparam logic [2:0] F3_SH = 3'b001;
    localparam logic [2:0] F3_SW = 3'b010;

    typedef struct packed {
        logic [2:0]  funct3;
        logic [31:0] addr;
        logic [31:0] data;
    } store_entry_t;

    typedef enum logic [1:0] {
        IDLE,
        BEAT0,
        BEAT1
    } store_state_t;

    // Returns {be8, d64}: an 8-byte window starting at the aligned word, so bytes
    // that spill past the word boundary land in the upper half (second beat).
    function automatic logic [71:0] fmt_store(input logic [2:0]  funct3,
                                              input logic [1:0]  offset,
                                              input logic [31:0] data);
        logic [3:0]  mask;
        logic [31:0] data_masked;
        logic [7:0]  be8;
        logic [63:0] d64;
        case (funct3)
            F3_SB:   mask = 4'h1;
            F3_SH:   mask = 4'h3;
            F3_SW:   mask = 4'hf;
            default: mask = 4'h0;
        endcase
        data_masked = data & {{8{mask[3]}}, {8{mask[2]}}, {8{mask[1]}}, {8{mask[0]}}};
        d64 = {32'h0, data_masked} << {offset, 3'b000};
        be8 = {4'h0, mask} << offset;
        return {be8, d64};
    endfunction

endpackage

// File: rtl/store_fifo.sv
// In-order FIFO of pending stores. Pointers carry an extra wrap bit so that
// full and empty are distinguishable without a separate counter.
module store_fifo
    import store_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  store_entry_t din,
    output store_entry_t head,
    output logic         full,
    output logic         empty,
    output logic         single
);

    localparam int unsigned AW = $clog2(DEPTH);

    store_entry_t   mem [DEPTH];
    logic [AW:0]    wptr_q;
    logic [AW:0]    rptr_q;
    logic [AW:0]    count;
    logic           do_push;
    logic           do_pop;

    assign empty   = (wptr_q == rptr_q);
    assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign count   = wptr_q - rptr_q;
    assign single  = (count == {{AW{1'b0}}, 1'b1});
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rptr_q[AW-1:0]];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (do_push) begin
                wptr_q <= wptr_q + {{AW{1'b0}}, 1'b1};
            end
            if (do_pop) begin
                rptr_q <= rptr_q + {{AW{1'b0}}, 1'b1};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr_q[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/store_unit.sv
// Store unit: validates SB/SH/SW requests, queues them in order and drains each
// to memory as one or two word-aligned write beats with byte enables.
module store_unit
    import store_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        mem_req,
    input  logic        mem_ack,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    output logic        empty,
    output logic        st_err
);

    store_state_t state_q, state_d;
    store_entry_t in_entry;
    store_entry_t head;
    logic         fifo_full;
    logic         fifo_empty;
    logic         fifo_single;
    logic         f3_ok;
    logic         accept;
    logic         push;
    logic         pop;
    logic         more;
    logic         split;
    logic         st_err_q;
    logic [71:0]  fmt;
    logic [7:0]   be8;
    logic [63:0]  d64;
    logic [31:0]  base;

    assign f3_ok    = (funct3 == F3_SB) || (funct3 == F3_SH) || (funct3 == F3_SW);
    assign in_ready = !fifo_full;
    assign accept   = in_valid && in_ready;
    assign push     = accept && f3_ok;
    assign in_entry = '{funct3: funct3, addr: addr, data: wdata};

    store_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk    (clk),
        .reset  (reset),
        .push   (push),
        .pop    (pop),
        .din    (in_entry),
        .head   (head),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .single (fifo_single)
    );

    assign fmt   = fmt_store(head.funct3, head.addr[1:0], head.data);
    assign be8   = fmt[71:64];
    assign d64   = fmt[63:0];
    assign split = |be8[7:4];
    assign base  = {head.addr[31:2], 2'b00};
    // A same-cycle push keeps the drain going without an idle bubble.
    assign more  = !fifo_single || push;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            st_err_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            st_err_q <= accept && !f3_ok;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    state_d = BEAT0;
                end
            end
            BEAT0: begin
                if (mem_ack) begin
                    if (split) begin
                        state_d = BEAT1;
                    end else begin
                        state_d = more ? BEAT0 : IDLE;
                    end
                end
            end
            BEAT1: begin
                if (mem_ack) begin
                    state_d = more ? BEAT0 : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_req   = 1'b0;
        pop       = 1'b0;
        mem_addr  = base;
        mem_be    = be8[3:0];
        mem_wdata = d64[31:0];
        case (state_q)
            BEAT0: begin
                mem_req = 1'b1;
                pop     = mem_ack && !split;
            end
            BEAT1: begin
                mem_req   = 1'b1;
                pop       = mem_ack;
                mem_addr  = base + 32'd4;
                mem_be    = be8[7:4];
                mem_wdata = d64[63:32];
            end
            default: ;
        endcase
    end

    assign empty  = fifo_empty && (state_q == IDLE);
    assign st_err = st_err_q;

endmodule

// File: doc/store_unit.md
# store_unit

Store-side counterpart of the load extender. It accepts SB/SH/SW requests from the execute stage, buffers them in a small in-order FIFO, and drains each one to data memory as word-aligned writes. Each write carries lane-shifted data and byte enables. A store whose bytes straddle a word boundary is split into two consecutive word writes.

## Interface
- `DEPTH`, default 4: store FIFO entries; power of two, ≥2.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high; clears FIFO, FSM and error flag.
- `in_valid` in 1: store request valid.
- `in_ready` out 1: `!full`; request accepted when `in_valid && in_ready`.
- `funct3` in 3: 000 SB, 001 SH, 010 SW; any other value is invalid.
- `addr` in 32: byte address.
- `wdata` in 32: rs2 value; the low 1/2/4 bytes are stored.
- `mem_req` out 1: write beat valid.
- `mem_ack` in 1: memory accepts the beat this cycle.
- `mem_addr` out 32: word address; `[1:0]`=00.
- `mem_wdata` out 32: lane-aligned write data; disabled lanes are 0.
- `mem_be` out 4: byte enables; bit i enables byte lane i.
- `empty` out 1: FIFO empty and FSM idle.
- `st_err` out 1: one-cycle pulse for an invalid `funct3`.

## Operation
- Push:
  - A valid `funct3` on an accepted request pushes {`funct3`, `addr`, `wdata`}.
  - An invalid `funct3` is consumed but not pushed; `st_err`=1 on the next cycle.
- No bypass: a full FIFO refuses input even in a cycle where it pops.
- Formatting of the head entry (combinational):
  - o=`addr[1:0]`; n=1/2/4 bytes; mask=0x1/0x3/0xF.
  - `d64` = zero-extended masked `wdata` << 8·o.
  - `be8` = mask << o.
- Beat 0: `mem_addr`=`addr & ~3`, `mem_be`=`be8[3:0]`, `mem_wdata`=`d64[31:0]`.
- Beat 1: exists only if `be8[7:4]`≠0. `mem_addr`=beat-0 address + 4, wrapping mod 2^32. `mem_be`=`be8[7:4]`, `mem_wdata`=`d64[63:32]`.
- FSM states: IDLE, BEAT0, BEAT1.
  - IDLE→BEAT0 when the FIFO is not empty.
  - BEAT0 on ack: go to BEAT1 if split; otherwise pop, then go to BEAT0 if entries remain, else IDLE.
  - BEAT1 on ack: pop, then go to BEAT0 if entries remain, else IDLE.
- `mem_req`=1 in BEAT0 and BEAT1.
- While `mem_req`=1 and no ack, `mem_addr`, `mem_wdata` and `mem_be` are held stable.
- Stores drain strictly in program order.

## Timing
- Reset values (asynchronous): `mem_req`=0, `st_err`=0, `empty`=1, `in_ready`=1. `mem_addr`, `mem_wdata` and `mem_be` are don't-care while `mem_req`=0.
- Latency: a push at edge N gives `mem_req`=1 in cycle N+1 at the earliest.
- `mem_ack` may be asserted in the same cycle as `mem_req`; the beat then completes at that edge.
- Throughput:
  - With `mem_ack` tied high: one unsplit store per cycle, and a split store takes 2 cycles.
  - The next entry's `mem_req` follows the last ack with no bubble.
- `mem_ack` while `mem_req`=0 is ignored.
- Push and pop in the same cycle: count unchanged.
- Read and write pointers wrap modulo `DEPTH`; an extra wrap bit distinguishes full from empty.
- Reset mid-beat: `mem_req` drops immediately and the in-flight store is abandoned. The memory side must tolerate a dropped request.

## Structure
- Package `store_pkg`:
  - constants `F3_SB`/`F3_SH`/`F3_SW`;
  - `store_entry_t` struct {funct3, addr, data};
  - `store_state_t` enum {IDLE, BEAT0, BEAT1};
  - function `fmt_store` returning {`be8`, `d64`}.
- Sub-module `store_fifo`: parameterised synchronous FIFO of `store_entry_t`, with `push`/`pop`/`full`/`empty` and a head output.
- Top level `store_unit`: funct3 check, FSM and formatting.

## Test plan
- **SB byte lane:** SB `addr`=0x1003, `wdata`=0xAABBCCDD, ack tied high → one beat: `mem_addr`=0x1000, `mem_be`=1000, `mem_wdata`=0xDD000000.
- **SH aligned:** SH `addr`=0x2002, `wdata`=0x12345678 → one beat: 0x2000, `mem_be`=1100, `mem_wdata`=0x56780000.
- **Split SW:** SW `addr`=0x3001, `wdata`=0x11223344 → beat 0: 0x3000, 1110, 0x22334400; beat 1: 0x3004, 0001, 0x00000011.
- **Split SH:** SH `addr`=0x2003, `wdata`=0x0000BEEF → beat 0: 0x2000, 1000, 0xEF000000; beat 1: 0x2004, 0001, 0x000000BE.
- **Full FIFO and ordering:** hold `mem_ack`=0 and push 4 SW stores to 0x0, 0x4, 0x8, 0xC → `in_ready`=0 after the 4th; a 5th is not accepted.
  - Then hold ack high → addresses drain in order, one per cycle, then `empty`=1.
- **Invalid funct3 and reset:**
  - `funct3`=011 → `st_err` pulses for one cycle and no `mem_req` follows.
  - Assert `reset` during BEAT1 of the split SW → `mem_req`=0 in the same cycle, `empty`=1, `in_ready`=1.
